// File: rtl/top_level_cpu.sv
// Single-cycle 8-bit accumulator CPU: PC, instruction ROM, 8x8 register file (r0 = ACC),
// ALU with Z/C flags and a byte-wide data RAM. HALT freezes all architectural state until reset.

module cpu_irom #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [8:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [8:0]    o_rdata
);
  logic [8:0] core [0:(2**AW)-1];

  // Load port exists for program download; the CPU itself never writes the ROM.
  always_ff @(posedge i_clk)
    if (i_we) core[i_waddr] <= i_wdata;

  assign o_rdata = core[i_raddr];
endmodule

module cpu_dmem #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);
  logic [7:0] core [0:(2**AW)-1];

  always_ff @(posedge i_clk)
    if (i_we) core[i_addr] <= i_wdata;

  assign o_rdata = core[i_addr];
endmodule

module top_level_cpu #(
  parameter int PC_W  = 10,
  parameter int DM_AW = 8
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  localparam logic [3:0] OP_LDI  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_MOVF = 4'b0010;
  localparam logic [3:0] OP_LD   = 4'b0011;
  localparam logic [3:0] OP_ST   = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_SH   = 4'b1011;
  localparam logic [3:0] OP_BZ   = 4'b1100;
  localparam logic [3:0] OP_BNZ  = 4'b1101;
  localparam logic [3:0] OP_JMP  = 4'b1110;

  logic [PC_W-1:0] r_pc;
  logic [7:0]      r_regs [8];
  logic            r_z, r_c, r_done;

  logic [8:0]       w_instr;
  logic [3:0]       w_op;
  logic [4:0]       w_field;
  logic [2:0]       w_rs;
  logic [7:0]       w_acc, w_rsval, w_dm_rdata;
  logic [DM_AW-1:0] w_dm_addr;
  logic [8:0]       w_sum9, w_dif9;
  logic [PC_W-1:0]  w_off, w_pc_nx;
  logic             w_wr_en, w_z_we, w_c_we, w_c_nx, w_dm_we, w_halt, w_br;
  logic [2:0]       w_wr_idx;
  logic [7:0]       w_wr_data;

  cpu_irom #(.AW(PC_W)) instructions (
    .i_clk   (clk),
    .i_we    (1'b0),
    .i_waddr ('0),
    .i_wdata (9'd0),
    .i_raddr (r_pc),
    .o_rdata (w_instr)
  );

  cpu_dmem #(.AW(DM_AW)) dm1 (
    .i_clk   (clk),
    .i_we    (w_dm_we),
    .i_addr  (w_dm_addr),
    .i_wdata (w_acc),
    .o_rdata (w_dm_rdata)
  );

  assign w_op      = w_instr[8:5];
  assign w_field   = w_instr[4:0];
  assign w_rs      = w_instr[2:0];
  assign w_acc     = r_regs[0];
  assign w_rsval   = r_regs[w_rs];
  assign w_dm_addr = DM_AW'(w_rsval);
  assign w_sum9    = {1'b0, w_acc} + {1'b0, w_rsval};
  assign w_dif9    = {1'b0, w_acc} - {1'b0, w_rsval};
  assign w_off     = {{(PC_W-5){w_field[4]}}, w_field};

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = 3'd0;
    w_wr_data = w_acc;
    w_z_we    = 1'b0;
    w_c_we    = 1'b0;
    w_c_nx    = r_c;
    w_dm_we   = 1'b0;
    w_halt    = 1'b0;
    w_br      = 1'b0;
    case (w_op)
      OP_LDI:  begin w_wr_en = 1'b1; w_wr_data = {3'b000, w_field}; end
      OP_MOV:  begin w_wr_en = 1'b1; w_wr_idx = w_rs; end
      OP_MOVF: begin w_wr_en = 1'b1; w_z_we = 1'b1; w_wr_data = w_rsval; end
      OP_LD:   begin w_wr_en = 1'b1; w_z_we = 1'b1; w_wr_data = w_dm_rdata; end
      OP_ST:   w_dm_we = ~r_done;
      OP_ADD:  begin
        w_wr_en = 1'b1; w_z_we = 1'b1; w_c_we = 1'b1;
        w_wr_data = w_sum9[7:0]; w_c_nx = w_sum9[8];
      end
      // C after SUB is the inverted borrow, i.e. set when ACC >= r[rs]
      OP_SUB:  begin
        w_wr_en = 1'b1; w_z_we = 1'b1; w_c_we = 1'b1;
        w_wr_data = w_dif9[7:0]; w_c_nx = ~w_dif9[8];
      end
      OP_AND:  begin w_wr_en = 1'b1; w_z_we = 1'b1; w_wr_data = w_acc & w_rsval; end
      OP_XOR:  begin w_wr_en = 1'b1; w_z_we = 1'b1; w_wr_data = w_acc ^ w_rsval; end
      OP_OR:   begin w_wr_en = 1'b1; w_z_we = 1'b1; w_wr_data = w_acc | w_rsval; end
      OP_SH:   begin
        w_wr_en = 1'b1; w_z_we = 1'b1; w_c_we = 1'b1;
        if (w_field[0]) begin w_wr_data = {1'b0, w_acc[7:1]}; w_c_nx = w_acc[0]; end
        else            begin w_wr_data = {w_acc[6:0], 1'b0}; w_c_nx = w_acc[7]; end
      end
      OP_HALT: w_halt = 1'b1;
      OP_BZ:   w_br = r_z;
      OP_BNZ:  w_br = ~r_z;
      OP_JMP:  w_br = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    if (w_halt)    w_pc_nx = r_pc;
    else if (w_br) w_pc_nx = r_pc + w_off;
    else           w_pc_nx = r_pc + PC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (!r_done) begin
      r_pc <= w_pc_nx;
      if (w_wr_en) r_regs[w_wr_idx] <= w_wr_data;
      if (w_z_we)  r_z <= (w_wr_data == 8'd0);
      if (w_c_we)  r_c <= w_c_nx;
      if (w_halt)  r_done <= 1'b1;
    end
  end

  assign done = r_done;
endmodule

// File: tb/tb_top_level_cpu.sv
// Directed bench for top_level_cpu: preloads ROM/RAM hierarchically and checks
// results, cycle counts and reset behaviour against hand-computed values.

module tb_top_level_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic done;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [8:0] prog [$];

  top_level_cpu dut (.clk(clk), .reset(reset), .done(done));

  always #5 clk = ~clk;

  function automatic logic [8:0] I(input logic [3:0] op, input logic [4:0] f);
    return {op, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) dut.instructions.core[i] = 9'h120;
    for (int i = 0; i < prog.size(); i++) dut.instructions.core[i] = prog[i];
  endtask

  task automatic restart();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic prog_xfer(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                           input logic [3:0] alu_op);
    prog = '{I(4'h0, a), I(4'h1, 5'd1), I(4'h3, 5'd1), I(4'h1, 5'd2),
             I(4'h0, b), I(4'h1, 5'd1), I(4'h3, 5'd1), I(alu_op, 5'd2), I(4'h1, 5'd3),
             I(4'h0, d), I(4'h1, 5'd1), I(4'h2, 5'd3), I(4'h4, 5'd1), I(4'h9, 5'd0)};
    load_prog();
  endtask

  initial begin
    // reset state
    #12;
    chk("reset_state", {22'd0, dut.r_pc}, 32'd0);
    chk("reset_flags", {dut.r_done, dut.r_z, dut.r_c, dut.r_regs[0]}, 32'd0);

    // XOR transfer through memory
    dut.dm1.core[0] = 8'hF0; dut.dm1.core[1] = 8'hCC;
    prog_xfer(5'd0, 5'd1, 5'd2, 4'h8);
    restart();
    edges(13);
    chk("xor_done_early", {31'd0, done}, 32'd0);
    edges(1);
    chk("xor_done", {31'd0, done}, 32'd1);
    chk("xor_dm2", {24'd0, dut.dm1.core[2]}, 32'h3C);

    // AND transfer
    dut.dm1.core[3] = 8'hC3; dut.dm1.core[4] = 8'h55;
    prog_xfer(5'd3, 5'd4, 5'd5, 4'h7);
    restart();
    edges(14);
    chk("and_done", {31'd0, done}, 32'd1);
    chk("and_dm5", {24'd0, dut.dm1.core[5]}, 32'h41);

    // PC stepping then HALT freeze
    prog.delete();
    for (int i = 0; i < 9; i++) prog.push_back(I(4'h0, 5'(i)));
    prog.push_back(9'b100100000);
    load_prog();
    restart();
    chk("step_pc0", {22'd0, dut.r_pc}, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      edges(1);
      chk($sformatf("step_pc%0d", k), {21'd0, done, dut.r_pc}, 32'(k));
    end
    edges(1);
    chk("halt_edge", {21'd0, done, dut.r_pc}, {21'd0, 1'b1, 10'd9});
    edges(3);
    chk("halt_frozen", {13'd0, done, dut.r_pc, dut.r_regs[0]}, {13'd0, 1'b1, 10'd9, 8'd8});

    // ADD carry, SUB zero, SUB borrow, shift right
    prog = '{I(4'h0, 5'h1E), I(4'h1, 5'd1), I(4'h5, 5'd1), I(4'h1, 5'd1),
             I(4'h5, 5'd1), I(4'h1, 5'd1), I(4'h5, 5'd1), I(4'h1, 5'd1),
             I(4'h0, 5'h1F), I(4'h5, 5'd1), I(4'h1, 5'd2), I(4'h2, 5'd1),
             I(4'h6, 5'd1), I(4'h0, 5'd1), I(4'h6, 5'd1), I(4'hB, 5'd1), I(4'h9, 5'd0)};
    load_prog();
    restart();
    edges(10);
    chk("add_carry", {22'd0, dut.r_z, dut.r_c, dut.r_regs[0]}, {22'd0, 1'b0, 1'b1, 8'h0F});
    chk("add_r1", {24'd0, dut.r_regs[1]}, 32'hF0);
    edges(3);
    chk("sub_zero", {22'd0, dut.r_z, dut.r_c, dut.r_regs[0]}, {22'd0, 1'b1, 1'b1, 8'h00});
    edges(2);
    chk("sub_borrow", {22'd0, dut.r_z, dut.r_c, dut.r_regs[0]}, {22'd0, 1'b0, 1'b0, 8'h11});
    edges(1);
    chk("sh_right", {22'd0, dut.r_z, dut.r_c, dut.r_regs[0]}, {22'd0, 1'b0, 1'b1, 8'h08});
    edges(1);
    chk("alu_done", {24'd0, done, dut.r_regs[2][6:0]}, {24'd0, 1'b1, 7'h0F});

    // branches: BZ not taken, JMP +3, countdown of 5 with BNZ -2
    prog = '{I(4'h0, 5'd1), I(4'h1, 5'd1), I(4'h2, 5'd1), I(4'hC, 5'd3),
             I(4'hE, 5'd3), I(4'h0, 5'h1F), I(4'h1, 5'd5), I(4'h0, 5'd5),
             I(4'hF, 5'd0), I(4'h6, 5'd1), I(4'hD, 5'b11110), I(4'h9, 5'd0)};
    load_prog();
    restart();
    edges(21);
    chk("loop_not_done", {31'd0, done}, 32'd0);
    edges(1);
    chk("loop_done", {31'd0, done}, 32'd1);
    chk("loop_state", {15'd0, dut.r_z, dut.r_regs[5], dut.r_regs[0]}, {15'd0, 1'b1, 8'd0, 8'd0});

    // async reset mid-program, then rerun
    dut.dm1.core[2] = 8'h00;
    prog_xfer(5'd0, 5'd1, 5'd2, 4'h8);
    restart();
    edges(8);
    chk("mid_r2", {16'd0, dut.r_regs[1], dut.r_regs[2]}, 32'h01F0);
    #2 reset = 1'b1;
    #1;
    chk("async_pc_done", {21'd0, done, dut.r_pc}, 32'd0);
    chk("async_regs", {dut.r_regs[0], dut.r_regs[1], dut.r_regs[2], dut.r_regs[3]}, 32'd0);
    @(negedge clk); reset = 1'b0;
    #1;
    edges(14);
    chk("rerun_done", {31'd0, done}, 32'd1);
    chk("rerun_dm2", {24'd0, dut.dm1.core[2]}, 32'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
